pingpong_buffer_ctrl: RTL

//  Sequences the two note-lane y-position RAM banks as a ping-pong frame buffer.
//  - Accepts one frame of y values from the update stage and writes them into the back bank.
//  - Routes VGA read requests to the front bank.
//  - Swaps the banks on vsync once the back bank is complete.
//  - Sits between the y-update logic and the two single-port lane RAMs, under the VGA top.

---
 rtl/pingpong_buffer_ctrl_pkg.sv | 20 ++
 rtl/pingpong_buffer_ctrl_if.sv | 28 ++
 rtl/pingpong_rd_mux.sv | 36 +++
 rtl/pingpong_buffer_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pingpong_buffer_ctrl_pkg.sv
// Shared definitions for the ping-pong lane-buffer controller:
// FSM state encodings and default bus widths.
package pingpong_buffer_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2,
        ST_SWAP  = 2'd3
    } pp_state_t;

    // True when the write pointer sits on the final entry of a frame
    function automatic logic is_last_addr(input logic [ADDR_W_DEF-1:0] addr);
        return (addr == {ADDR_W_DEF{1'b1}});
    endfunction

endpackage

// File: rtl/pingpong_buffer_ctrl_if.sv
// Client-side bus of the ping-pong controller: the y-update handshake
// and the VGA read request/response.
interface pingpong_buffer_ctrl_if
    import pingpong_buffer_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              upd_valid;
    logic [DATA_W-1:0] upd_y;
    logic              upd_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    // Update stage / VGA side
    modport master (
        output upd_valid, upd_y, rd_en, rd_addr,
        input  upd_ready, rd_data, rd_valid
    );

    // Controller side
    modport slave (
        input  upd_valid, upd_y, rd_en, rd_addr,
        output upd_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/pingpong_rd_mux.sv
// Read-return path: captures which bank was front when a request was
// issued, then registers that bank's RAM output one cycle later.
module pingpong_rd_mux #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rd_en,
    input  logic              front,
    input  logic [DATA_W-1:0] ram1_q,
    input  logic [DATA_W-1:0] ram2_q,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    logic sel_reg;
    logic pend_reg;

    // Two-stage pipeline: request/bank-select, then registered data mux
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel_reg  <= 1'b0;
            pend_reg <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            pend_reg <= rd_en;
            if (rd_en) begin
                sel_reg <= front;
            end
            rd_valid <= pend_reg;
            if (pend_reg) begin
                rd_data <= sel_reg ? ram2_q : ram1_q;
            end
        end
    end
endmodule

// File: rtl/pingpong_buffer_ctrl.sv
// Ping-pong frame-buffer controller for the two note-lane y-position RAMs.
// Fills the back bank from the update stage, serves VGA reads from the
// front bank and swaps banks on vsync once the back bank is complete.
// Optional feature macro: PINGPONG_DROP_CNT_EN (dropped-frame counter).
module pingpong_buffer_ctrl
    import pingpong_buffer_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    vsync,
    input  logic                    map,
    pingpong_buffer_ctrl_if.slave   bus,
    output logic                    ram1_wr_en,
    output logic                    ram1_rd_en,
    output logic [ADDR_W-1:0]       ram1_addr,
    output logic [DATA_W-1:0]       ram1_wdata,
    input  logic [DATA_W-1:0]       ram1_q,
    output logic                    ram2_wr_en,
    output logic                    ram2_rd_en,
    output logic [ADDR_W-1:0]       ram2_addr,
    output logic [DATA_W-1:0]       ram2_wdata,
    input  logic [DATA_W-1:0]       ram2_q,
    output logic                    front,
    output logic                    swap_pulse,
    output logic [7:0]              drop_cnt
);
    pp_state_t         state_reg;
    logic              front_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic              upd_ready_reg;
    logic              swap_pulse_reg;
    logic              map_q;
    logic              map_chg;
    logic              accept;
    logic              last_addr;
    logic [DATA_W-1:0] rd_data_int;
    logic              rd_valid_int;

    // A map change cancels the fill; it also suppresses any write offered
    // in the same cycle so a stale value never lands in the new frame.
    assign map_chg   = (map != map_q);
    assign accept    = bus.upd_valid & upd_ready_reg & ~map_chg;
    assign last_addr = (wr_addr_reg == {ADDR_W{1'b1}});

    // Track the selected map every cycle to detect changes
    always_ff @(posedge clk) begin
        map_q <= map;
    end

    // Frame sequencing FSM with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            front_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            upd_ready_reg  <= 1'b0;
            swap_pulse_reg <= 1'b0;
        end else begin
            swap_pulse_reg <= 1'b0;
            if (state_reg != ST_IDLE && map_chg) begin
                state_reg     <= ST_IDLE;
                wr_addr_reg   <= '0;
                upd_ready_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (vsync) begin
                            state_reg     <= ST_FILL;
                            wr_addr_reg   <= '0;
                            upd_ready_reg <= 1'b1;
                        end
                    end
                    ST_FILL: begin
                        // vsync here is a dropped frame: keep filling
                        if (accept) begin
                            wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
                            if (last_addr) begin
                                state_reg     <= ST_READY;
                                upd_ready_reg <= 1'b0;
                            end
                        end
                    end
                    ST_READY: begin
                        if (vsync) begin
                            state_reg      <= ST_SWAP;
                            swap_pulse_reg <= 1'b1;
                        end
                    end
                    ST_SWAP: begin
                        // The swapping vsync also opens the next fill
                        front_reg     <= ~front_reg;
                        state_reg     <= ST_FILL;
                        wr_addr_reg   <= '0;
                        upd_ready_reg <= 1'b1;
                    end
                    default: begin
                        state_reg     <= ST_IDLE;
                        upd_ready_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Writes target only the back bank, reads only the front bank
    always_comb begin
        ram1_wr_en = accept & front_reg;
        ram2_wr_en = accept & ~front_reg;
        ram1_rd_en = bus.rd_en & ~front_reg;
        ram2_rd_en = bus.rd_en & front_reg;
        ram1_addr  = ram1_wr_en ? wr_addr_reg : bus.rd_addr;
        ram2_addr  = ram2_wr_en ? wr_addr_reg : bus.rd_addr;
        ram1_wdata = ram1_wr_en ? bus.upd_y : '0;
        ram2_wdata = ram2_wr_en ? bus.upd_y : '0;
    end

    pingpong_rd_mux #(
        .DATA_W (DATA_W)
    ) u_rd_mux (
        .clk      (clk),
        .resetn   (resetn),
        .rd_en    (bus.rd_en),
        .front    (front_reg),
        .ram1_q   (ram1_q),
        .ram2_q   (ram2_q),
        .rd_data  (rd_data_int),
        .rd_valid (rd_valid_int)
    );

    assign bus.upd_ready = upd_ready_reg;
    assign bus.rd_data   = rd_data_int;
    assign bus.rd_valid  = rd_valid_int;
    assign front         = front_reg;
    assign swap_pulse    = swap_pulse_reg;

`ifdef PINGPONG_DROP_CNT_EN
    logic [7:0] drop_cnt_reg;

    // Count vsyncs that arrive mid-fill, saturating; an abort takes precedence
    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_cnt_reg <= 8'd0;
        end else if (state_reg == ST_FILL && vsync && !map_chg && drop_cnt_reg != 8'hFF) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule
